fl_frame_arbiter: RTL and testbench
===================================

Name: fl_frame_arbiter

Overview:
- Frame-granular round-robin arbiter sharing one FrameLink datapath (e.g. the FL first-insert unit) between PORTS FrameLink requesters.
- Locks the grant for the whole frame, SOF to EOF, so frames are never interleaved.
- Publishes the granted port index on TX_PORT, stable for the whole frame, so the downstream first-insert unit can take it as its inserted word.

Parameters:
- DATA_WIDTH, 32, FrameLink data width in bits (8..128, power of 2).
- PORTS, 2, number of RX requesters (2..8).
- PORT_BITS, 1, width of the port index; must equal max(1, ceil(log2(PORTS))).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  PORTS  per-port arbitration enable; 0 = port never granted.
- RX_DATA  in  PORTS*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- RX_REM  in  PORTS*log2(DATA_WIDTH/8)  per-port valid-bytes field, packed the same way as RX_DATA.
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  PORTS each  per-port FrameLink framing, active-low.
- RX_SRC_RDY_N  in  PORTS  per-port source ready, active-low.
- RX_DST_RDY_N  out  PORTS  per-port destination ready, active-low.
- TX_DATA  out  DATA_WIDTH  muxed data.
- TX_REM  out  log2(DATA_WIDTH/8)  muxed valid-bytes field.
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  muxed framing.
- TX_SRC_RDY_N  out  1  source ready.
- TX_DST_RDY_N  in  1  downstream destination ready.
- TX_PORT  out  PORT_BITS  index of the granted port.

Behaviour:
- Clock and reset: single clock CLK. RESET is asynchronous, active-high.
- Registered state:
  - FSM {IDLE, LOCKED}.
  - grant register G (PORT_BITS).
  - round-robin pointer P (PORT_BITS).
- Reset values: FSM=IDLE, G=0, P=0, TX_PORT=0, TX_SRC_RDY_N=1, all RX_DST_RDY_N=1.
  - TX_DATA/REM/SOF/EOF/SOP/EOP follow port 0 through the mux; their value is don't-care while TX_SRC_RDY_N=1.
- Request definition: req[i] = EN[i] & !RX_SRC_RDY_N[i] & !RX_SOF_N[i].
  - A port presenting a non-SOF word while not granted is never granted and is stalled (RX_DST_RDY_N=1).
- IDLE:
  - TX_SRC_RDY_N=1 and all RX_DST_RDY_N=1.
  - If any req: winner = first i with req[i], searching P, P+1, …, PORTS-1, 0, …, P-1 (mod PORTS).
  - On the clock edge: G<=winner, FSM<=LOCKED.
  - No req: stay in IDLE.
  - Arbitration costs exactly one idle cycle between frames; first TX word is valid the cycle after the request is seen.
- LOCKED, combinational mux on G:
  - TX_* = RX_*[G].
  - TX_SRC_RDY_N = RX_SRC_RDY_N[G].
  - RX_DST_RDY_N[G] = TX_DST_RDY_N; every other RX_DST_RDY_N = 1.
  - TX_PORT = G.
  - Zero-latency pass-through.
- Release: on a transfer cycle (!TX_SRC_RDY_N & !TX_DST_RDY_N & !TX_EOF_N): FSM<=IDLE, P<=(G+1) mod PORTS.
  - A single-word frame (SOF and EOF on the same word) is granted, then released on its one transfer.
- Stall handling: TX_DST_RDY_N=1 or RX_SRC_RDY_N[G]=1 holds LOCKED with no state change; G and TX_PORT stay stable.
- EN changes: an EN deassertion during LOCKED does not abort the current frame; EN is sampled only in IDLE.
- Fairness: with all ports requesting continuously, grants rotate 0,1,…,PORTS-1,0…; no port waits more than PORTS-1 frames.
- PORTS not a power of 2: pointer wrap uses mod PORTS; indices ≥ PORTS are never produced.
- Reset mid-frame: immediate return to reset values. The partially forwarded frame is truncated; upstream must restart it.

Test Plan:
1. PORTS=2, only port 1 sends a 3-word frame, TX_DST_RDY_N=0.
   - Cycle 0: request seen. Cycles 1–3: TX carries words 1–3 with TX_PORT=1, RX_DST_RDY_N=2'b01.
   - After EOF: FSM=IDLE, P=0.
2. PORTS=4, all ports continuously offer 2-word frames.
   - Grant order 0,1,2,3,0.
   - Exactly one idle TX cycle between consecutive frames; no interleaving of SOF/EOF.
3. Port 0 frame, TX_DST_RDY_N=1 for 5 cycles mid-frame.
   - TX holds the same word; RX_DST_RDY_N[0]=1; TX_PORT stays 0; no word lost or duplicated.
4. EN=4'b1010 with all ports requesting: only ports 1 and 3 are granted, alternately.
   - Clear EN[1] while port 1 is LOCKED: its frame still completes.
5. Single-word frames (SOF=EOF) from ports 0 and 1 simultaneously, P=0.
   - Port 0 transferred in cycle 1, port 1 in cycle 3.
6. Assert RESET in the 2nd word of a 4-word frame.
   - Same cycle (asynchronous): TX_SRC_RDY_N=1, all RX_DST_RDY_N=1, TX_PORT=0.
   - After release: fresh arbitration starts from P=0.

Source files
------------

// File: rtl/fl_frame_arbiter.sv
// fl_frame_arbiter: frame-granular round-robin arbiter that shares one
// FrameLink datapath between PORTS requesters. A grant is held from SOF
// to EOF so frames never interleave. The granted index is published on
// tx_port for the whole frame.
//
// Handshake: all *_src_rdy_n / *_dst_rdy_n pairs are active-low
// valid/ready. A word moves on a rising clk edge exactly when both
// src_rdy_n and dst_rdy_n are 0 in the cycle before that edge. A source
// holds its word and framing stable until it is taken. A sink may change
// dst_rdy_n freely. The grant path is combinational, so the granted
// port's handshake passes through with zero latency.
module fl_frame_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int PORTS      = 2,
  parameter  int PORT_BITS  = 1,
  localparam int REM_WIDTH  = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PORTS-1:0]            en,
  input  logic [PORTS*DATA_WIDTH-1:0] rx_data,
  input  logic [PORTS*REM_WIDTH-1:0]  rx_rem,
  input  logic [PORTS-1:0]            rx_sof_n,
  input  logic [PORTS-1:0]            rx_eof_n,
  input  logic [PORTS-1:0]            rx_sop_n,
  input  logic [PORTS-1:0]            rx_eop_n,
  input  logic [PORTS-1:0]            rx_src_rdy_n,
  output logic [PORTS-1:0]            rx_dst_rdy_n,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic [REM_WIDTH-1:0]        tx_rem,
  output logic                        tx_sof_n,
  output logic                        tx_eof_n,
  output logic                        tx_sop_n,
  output logic                        tx_eop_n,
  output logic                        tx_src_rdy_n,
  input  logic                        tx_dst_rdy_n,
  output logic [PORT_BITS-1:0]        tx_port,
  output logic                        dbg_state,
  output logic [PORT_BITS-1:0]        dbg_ptr
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [PORT_BITS:0]   PORTS_W  = (PORT_BITS + 1)'(PORTS);
  localparam logic [PORT_BITS-1:0] LAST_IDX = PORT_BITS'(PORTS - 1);

  logic [0:0]           state;
  logic [PORT_BITS-1:0] grant;
  logic [PORT_BITS-1:0] ptr;

  logic [PORTS-1:0]      req;
  logic                  found;
  logic [PORT_BITS-1:0]  winner;
  logic [PORT_BITS:0]    cand;
  logic [PORT_BITS-1:0]  next_ptr;
  logic                  xfer_eof;

  logic [DATA_WIDTH-1:0] data_a [PORTS];
  logic [REM_WIDTH-1:0]  rem_a  [PORTS];

  // Unpack the flat per-port buses so the mux can index by grant.
  for (genvar i = 0; i < PORTS; i++) begin : g_unpack
    assign data_a[i] = rx_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign rem_a[i]  = rx_rem[i*REM_WIDTH +: REM_WIDTH];
  end

  // Only a ready SOF word on an enabled port can open a new frame.
  assign req = en & ~rx_src_rdy_n & ~rx_sof_n;

  // Round-robin search starting at ptr; the wrap stays inside 0..PORTS-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < PORTS; k++) begin
      cand = {1'b0, ptr} + (PORT_BITS + 1)'(k);
      if (cand >= PORTS_W) cand = cand - PORTS_W;
      if (!found && req[cand[PORT_BITS-1:0]]) begin
        found  = 1'b1;
        winner = cand[PORT_BITS-1:0];
      end
    end
  end

  // Pointer moves to the port after the one that just finished.
  assign next_ptr = (grant == LAST_IDX) ? '0 : grant + 1'b1;

  // Zero-latency data/handshake mux on the held grant.
  always_comb begin
    tx_data      = data_a[grant];
    tx_rem       = rem_a[grant];
    tx_sof_n     = rx_sof_n[grant];
    tx_eof_n     = rx_eof_n[grant];
    tx_sop_n     = rx_sop_n[grant];
    tx_eop_n     = rx_eop_n[grant];
    tx_src_rdy_n = 1'b1;
    rx_dst_rdy_n = '1;
    if (state == ST_LOCKED) begin
      tx_src_rdy_n        = rx_src_rdy_n[grant];
      rx_dst_rdy_n[grant] = tx_dst_rdy_n;
    end
  end

  assign xfer_eof = (state == ST_LOCKED) & ~tx_src_rdy_n & ~tx_dst_rdy_n & ~tx_eof_n;

  // Lock on a request in IDLE; release on the EOF transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= '0;
    end else if (state == ST_IDLE) begin
      if (found) begin
        grant <= winner;
        state <= ST_LOCKED;
      end
    end else begin
      if (xfer_eof) begin
        state <= ST_IDLE;
        ptr   <= next_ptr;
      end
    end
  end

  assign tx_port   = grant;
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_fl_frame_arbiter.sv
// Directed bench for fl_frame_arbiter with four ports of 32-bit data.
// Each port is driven by a small frame source; TX transfers are logged
// and compared against hand-built expected sequences.
module tb_fl_frame_arbiter;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int PB = 2;
  localparam int RW = 2;

  typedef logic [35:0] ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   en;
  logic [NP*DW-1:0] rx_data;
  logic [NP*RW-1:0] rx_rem;
  logic [NP-1:0]   rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n;
  logic [NP-1:0]   rx_dst_rdy_n;
  logic [DW-1:0]   tx_data;
  logic [RW-1:0]   tx_rem;
  logic            tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n;
  logic            tx_dst_rdy_n;
  logic [PB-1:0]   tx_port;
  logic            dbg_state;
  logic [PB-1:0]   dbg_ptr;

  int checks   = 0;
  int failures = 0;

  int src_len    [NP];
  int src_target [NP];
  int src_done   [NP];
  int src_wi     [NP];
  logic [NP-1:0] src_on;

  ent_t act_q[$];
  int   stamp_q[$];
  ent_t exp_q[$];
  int   cyc = 0;

  fl_frame_arbiter #(.DATA_WIDTH(DW), .PORTS(NP), .PORT_BITS(PB)) dut (
    .clk(clk), .reset(rst), .en(en),
    .rx_data(rx_data), .rx_rem(rx_rem),
    .rx_sof_n(rx_sof_n), .rx_eof_n(rx_eof_n), .rx_sop_n(rx_sop_n), .rx_eop_n(rx_eop_n),
    .rx_src_rdy_n(rx_src_rdy_n), .rx_dst_rdy_n(rx_dst_rdy_n),
    .tx_data(tx_data), .tx_rem(tx_rem),
    .tx_sof_n(tx_sof_n), .tx_eof_n(tx_eof_n), .tx_sop_n(tx_sop_n), .tx_eop_n(tx_eop_n),
    .tx_src_rdy_n(tx_src_rdy_n), .tx_dst_rdy_n(tx_dst_rdy_n),
    .tx_port(tx_port), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input int p, input int f, input int w);
    word_of = {16'(p), 8'(f), 8'(w)};
  endfunction

  function automatic ent_t ent(input int p, input int f, input int w, input int len);
    ent = {2'(p), (w == 0) ? 1'b0 : 1'b1, (w == len - 1) ? 1'b0 : 1'b1, word_of(p, f, w)};
  endfunction

  // frame sources: one frame per (target - done), word index advances on accept
  always_comb begin
    rx_data = '0;
    rx_rem  = '0;
    src_on  = '0;
    rx_src_rdy_n = '1;
    rx_sof_n = '1; rx_eof_n = '1; rx_sop_n = '1; rx_eop_n = '1;
    for (int i = 0; i < NP; i++) begin
      src_on[i]       = (src_done[i] < src_target[i]);
      rx_src_rdy_n[i] = !src_on[i];
      rx_sof_n[i]     = !(src_wi[i] == 0);
      rx_eof_n[i]     = !(src_wi[i] == src_len[i] - 1);
      rx_sop_n[i]     = rx_sof_n[i];
      rx_eop_n[i]     = rx_eof_n[i];
      rx_data[i*DW +: DW] = word_of(i, src_done[i], src_wi[i]);
      rx_rem[i*RW +: RW]  = 2'(src_wi[i]);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) src_wi[i] <= 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (src_on[i] && !rx_dst_rdy_n[i]) begin
          if (src_wi[i] == src_len[i] - 1) begin
            src_wi[i]   <= 0;
            src_done[i] <= src_done[i] + 1;
          end else begin
            src_wi[i] <= src_wi[i] + 1;
          end
        end
      end
    end
  end

  // TX log: words that will transfer on the coming rising edge
  always begin
    @(negedge clk);
    #3;
    cyc++;
    if (!rst && !tx_src_rdy_n && !tx_dst_rdy_n) begin
      act_q.push_back({tx_port, tx_sof_n, tx_eof_n, tx_data});
      stamp_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = '1;
    tx_dst_rdy_n = 1'b0;
    for (int i = 0; i < NP; i++) src_target[i] = src_done[i];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #4;
      if (act_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = '1;
    tx_dst_rdy_n = 1'b0;
    for (int i = 0; i < NP; i++) begin src_target[i] = 0; src_len[i] = 1; end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL reset tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
    checks++; if (rx_dst_rdy_n !== 4'hf) begin failures++; $display("FAIL reset rx_dst_rdy_n: got %b expected 1111", rx_dst_rdy_n); end
    checks++; if (tx_port !== 2'd0) begin failures++; $display("FAIL reset tx_port: got %0d expected 0", tx_port); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset state: got %b expected 0", dbg_state); end
    checks++; if (dbg_ptr !== 2'd0) begin failures++; $display("FAIL reset ptr: got %0d expected 0", dbg_ptr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL idle tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
  endtask

  task automatic test_single_port();
    int f0;
    @(negedge clk);
    f0 = src_done[1];
    src_len[1] = 3;
    src_target[1] = src_done[1] + 1;
    tx_dst_rdy_n = 1'b0;
    #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL single c0 tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
    checks++; if (rx_dst_rdy_n !== 4'hf) begin failures++; $display("FAIL single c0 rx_dst_rdy_n: got %b expected 1111", rx_dst_rdy_n); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (tx_src_rdy_n !== 1'b0) begin failures++; $display("FAIL single w%0d tx_src_rdy_n: got %b expected 0", k, tx_src_rdy_n); end
      checks++; if (tx_port !== 2'd1) begin failures++; $display("FAIL single w%0d tx_port: got %0d expected 1", k, tx_port); end
      checks++; if (rx_dst_rdy_n !== 4'b1101) begin failures++; $display("FAIL single w%0d rx_dst_rdy_n: got %b expected 1101", k, rx_dst_rdy_n); end
      checks++; if (tx_data !== word_of(1, f0, k)) begin failures++; $display("FAIL single w%0d tx_data: got %h expected %h", k, tx_data, word_of(1, f0, k)); end
      checks++; if (tx_rem !== 2'(k)) begin failures++; $display("FAIL single w%0d tx_rem: got %0d expected %0d", k, tx_rem, k); end
      checks++; if (tx_eof_n !== ((k == 2) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL single w%0d tx_eof_n: got %b expected %b", k, tx_eof_n, (k == 2) ? 1'b0 : 1'b1); end
      checks++; if (tx_sop_n !== ((k == 0) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL single w%0d tx_sop_n: got %b expected %b", k, tx_sop_n, (k == 0) ? 1'b0 : 1'b1); end
    end
    @(negedge clk); #1;
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL single end state: got %b expected 0", dbg_state); end
    checks++; if (dbg_ptr !== 2'd2) begin failures++; $display("FAIL single end ptr: got %0d expected 2", dbg_ptr); end
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL single end tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
  endtask

  task automatic test_round_robin();
    int f0[NP];
    int base;
    bit ok;
    do_reset();
    @(negedge clk);
    base = act_q.size();
    exp_q.delete();
    for (int i = 0; i < NP; i++) begin
      f0[i] = src_done[i];
      src_len[i] = 2;
      src_target[i] = src_done[i] + 2;
    end
    for (int n = 0; n < 8; n++)
      for (int w = 0; w < 2; w++) exp_q.push_back(ent(n % 4, f0[n % 4] + n / 4, w, 2));
    wait_xfers(base + 16, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr timeout: got %0d words expected 16", act_q.size() - base); end
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (base + j >= act_q.size() || act_q[base + j] !== exp_q[j]) begin
        failures++;
        $display("FAIL rr word[%0d]: got %h expected %h", j, (base + j < act_q.size()) ? act_q[base + j] : '0, exp_q[j]);
      end
    end
    for (int j = 1; j < 16; j++) begin
      checks++;
      if (base + j >= stamp_q.size() || stamp_q[base + j] - stamp_q[base] !== (j / 2) * 3 + j % 2) begin
        failures++;
        $display("FAIL rr spacing[%0d]: got %0d expected %0d", j,
                 (base + j < stamp_q.size()) ? stamp_q[base + j] - stamp_q[base] : -1, (j / 2) * 3 + j % 2);
      end
    end
  endtask

  task automatic test_stall();
    int f0;
    int base;
    bit ok;
    do_reset();
    @(negedge clk);
    base = act_q.size();
    f0 = src_done[0];
    src_len[0] = 4;
    src_target[0] = src_done[0] + 1;
    @(negedge clk);
    @(negedge clk);
    tx_dst_rdy_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++; if (tx_data !== word_of(0, f0, 1)) begin failures++; $display("FAIL stall[%0d] tx_data: got %h expected %h", s, tx_data, word_of(0, f0, 1)); end
      checks++; if (rx_dst_rdy_n !== 4'hf) begin failures++; $display("FAIL stall[%0d] rx_dst_rdy_n: got %b expected 1111", s, rx_dst_rdy_n); end
      checks++; if (tx_port !== 2'd0) begin failures++; $display("FAIL stall[%0d] tx_port: got %0d expected 0", s, tx_port); end
      checks++; if (tx_src_rdy_n !== 1'b0) begin failures++; $display("FAIL stall[%0d] tx_src_rdy_n: got %b expected 0", s, tx_src_rdy_n); end
      @(negedge clk);
    end
    tx_dst_rdy_n = 1'b0;
    wait_xfers(base + 4, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall timeout: got %0d words expected 4", act_q.size() - base); end
    repeat (3) @(negedge clk);
    #4;
    checks++; if (act_q.size() - base !== 4) begin failures++; $display("FAIL stall count: got %0d expected 4", act_q.size() - base); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (base + j >= act_q.size() || act_q[base + j] !== ent(0, f0, j, 4)) begin
        failures++;
        $display("FAIL stall word[%0d]: got %h expected %h", j, (base + j < act_q.size()) ? act_q[base + j] : '0, ent(0, f0, j, 4));
      end
    end
  endtask

  task automatic test_enable();
    int f0[NP];
    int f1, f3;
    int base;
    bit ok;
    do_reset();
    @(negedge clk);
    en = 4'b1010;
    base = act_q.size();
    exp_q.delete();
    for (int i = 0; i < NP; i++) begin
      f0[i] = src_done[i];
      src_len[i] = 2;
      src_target[i] = src_done[i] + 2;
    end
    for (int n = 0; n < 4; n++)
      for (int w = 0; w < 2; w++) exp_q.push_back(ent((n % 2) ? 3 : 1, f0[(n % 2) ? 3 : 1] + n / 2, w, 2));
    wait_xfers(base + 8, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL en timeout: got %0d words expected 8", act_q.size() - base); end
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (base + j >= act_q.size() || act_q[base + j] !== exp_q[j]) begin
        failures++;
        $display("FAIL en word[%0d]: got %h expected %h", j, (base + j < act_q.size()) ? act_q[base + j] : '0, exp_q[j]);
      end
    end
    // second phase: drop EN[1] while port 1 holds the grant
    @(negedge clk);
    base = act_q.size();
    f1 = src_done[1];
    f3 = src_done[3];
    src_target[1] = src_done[1] + 1;
    src_target[3] = src_done[3] + 1;
    @(negedge clk);
    en = 4'b1000;
    #1;
    checks++; if (tx_port !== 2'd1) begin failures++; $display("FAIL en locked tx_port: got %0d expected 1", tx_port); end
    checks++; if (tx_src_rdy_n !== 1'b0) begin failures++; $display("FAIL en locked tx_src_rdy_n: got %b expected 0", tx_src_rdy_n); end
    exp_q.delete();
    exp_q.push_back(ent(1, f1, 0, 2));
    exp_q.push_back(ent(1, f1, 1, 2));
    exp_q.push_back(ent(3, f3, 0, 2));
    exp_q.push_back(ent(3, f3, 1, 2));
    wait_xfers(base + 4, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL en drop timeout: got %0d words expected 4", act_q.size() - base); end
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (base + j >= act_q.size() || act_q[base + j] !== exp_q[j]) begin
        failures++;
        $display("FAIL en drop word[%0d]: got %h expected %h", j, (base + j < act_q.size()) ? act_q[base + j] : '0, exp_q[j]);
      end
    end
    checks++; if (src_done[0] !== f0[0]) begin failures++; $display("FAIL en port0 frames: got %0d expected %0d", src_done[0], f0[0]); end
    checks++; if (src_done[2] !== f0[2]) begin failures++; $display("FAIL en port2 frames: got %0d expected %0d", src_done[2], f0[2]); end
    @(negedge clk);
    src_target[0] = src_done[0];
    src_target[2] = src_done[2];
    en = '1;
  endtask

  task automatic test_single_word();
    int f0, f1;
    do_reset();
    @(negedge clk);
    f0 = src_done[0];
    f1 = src_done[1];
    src_len[0] = 1;
    src_len[1] = 1;
    src_target[0] = src_done[0] + 1;
    src_target[1] = src_done[1] + 1;
    #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL sw c0 tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
    @(negedge clk); #1;
    checks++; if (tx_port !== 2'd0) begin failures++; $display("FAIL sw c1 tx_port: got %0d expected 0", tx_port); end
    checks++; if (tx_src_rdy_n !== 1'b0) begin failures++; $display("FAIL sw c1 tx_src_rdy_n: got %b expected 0", tx_src_rdy_n); end
    checks++; if ({tx_sof_n, tx_eof_n} !== 2'b00) begin failures++; $display("FAIL sw c1 sof/eof: got %b expected 00", {tx_sof_n, tx_eof_n}); end
    checks++; if (rx_dst_rdy_n !== 4'b1110) begin failures++; $display("FAIL sw c1 rx_dst_rdy_n: got %b expected 1110", rx_dst_rdy_n); end
    checks++; if (tx_data !== word_of(0, f0, 0)) begin failures++; $display("FAIL sw c1 tx_data: got %h expected %h", tx_data, word_of(0, f0, 0)); end
    @(negedge clk); #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL sw c2 tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
    checks++; if (dbg_ptr !== 2'd1) begin failures++; $display("FAIL sw c2 ptr: got %0d expected 1", dbg_ptr); end
    @(negedge clk); #1;
    checks++; if (tx_port !== 2'd1) begin failures++; $display("FAIL sw c3 tx_port: got %0d expected 1", tx_port); end
    checks++; if (tx_src_rdy_n !== 1'b0) begin failures++; $display("FAIL sw c3 tx_src_rdy_n: got %b expected 0", tx_src_rdy_n); end
    checks++; if (rx_dst_rdy_n !== 4'b1101) begin failures++; $display("FAIL sw c3 rx_dst_rdy_n: got %b expected 1101", rx_dst_rdy_n); end
    checks++; if (tx_data !== word_of(1, f1, 0)) begin failures++; $display("FAIL sw c3 tx_data: got %h expected %h", tx_data, word_of(1, f1, 0)); end
    @(negedge clk); #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL sw c4 tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
    checks++; if (dbg_ptr !== 2'd2) begin failures++; $display("FAIL sw c4 ptr: got %0d expected 2", dbg_ptr); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL sw c4 state: got %b expected 0", dbg_state); end
  endtask

  task automatic test_reset_mid_frame();
    int f1, f2;
    int base;
    bit ok;
    do_reset();
    @(negedge clk);
    base = act_q.size();
    src_len[1] = 1;
    src_target[1] = src_done[1] + 1;
    wait_xfers(base + 1, 10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmf pre timeout: got %0d words expected 1", act_q.size() - base); end
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (dbg_ptr !== 2'd2) begin failures++; $display("FAIL rmf pre ptr: got %0d expected 2", dbg_ptr); end
    @(negedge clk);
    f2 = src_done[2];
    src_len[2] = 4;
    src_target[2] = src_done[2] + 1;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (tx_data !== word_of(2, f2, 1)) begin failures++; $display("FAIL rmf w1 tx_data: got %h expected %h", tx_data, word_of(2, f2, 1)); end
    checks++; if (tx_port !== 2'd2) begin failures++; $display("FAIL rmf w1 tx_port: got %0d expected 2", tx_port); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL rmf rst tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
    checks++; if (rx_dst_rdy_n !== 4'hf) begin failures++; $display("FAIL rmf rst rx_dst_rdy_n: got %b expected 1111", rx_dst_rdy_n); end
    checks++; if (tx_port !== 2'd0) begin failures++; $display("FAIL rmf rst tx_port: got %0d expected 0", tx_port); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL rmf rst state: got %b expected 0", dbg_state); end
    checks++; if (dbg_ptr !== 2'd0) begin failures++; $display("FAIL rmf rst ptr: got %0d expected 0", dbg_ptr); end
    @(negedge clk);
    rst = 1'b0;
    base = act_q.size();
    f1 = src_done[1];
    src_target[1] = src_done[1] + 1;
    #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++; $display("FAIL rmf c0 tx_src_rdy_n: got %b expected 1", tx_src_rdy_n); end
    @(negedge clk); #1;
    checks++; if (tx_port !== 2'd1) begin failures++; $display("FAIL rmf c1 tx_port: got %0d expected 1", tx_port); end
    exp_q.delete();
    exp_q.push_back(ent(1, f1, 0, 1));
    for (int w = 0; w < 4; w++) exp_q.push_back(ent(2, f2, w, 4));
    wait_xfers(base + 5, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmf timeout: got %0d words expected 5", act_q.size() - base); end
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (base + j >= act_q.size() || act_q[base + j] !== exp_q[j]) begin
        failures++;
        $display("FAIL rmf word[%0d]: got %h expected %h", j, (base + j < act_q.size()) ? act_q[base + j] : '0, exp_q[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_stall();
    test_enable();
    test_single_word();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
